// File: rtl/vec3_length_seq.sv
// Sequential 3-D vector length: |v| = sum * (1/sqrt(sum)), using one shared multiplier
// and an external inverse-sqrt unit. Optional macro VEC3_LENGTH_ZERO_BYPASS_EN short-cuts zero vectors.
module vec3_length_seq #(
  parameter int N    = 32,
  parameter int FRAC = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] vec_x,
  input  logic [N-1:0] vec_y,
  input  logic [N-1:0] vec_z,
  output logic         isq_req_valid,
  input  logic         isq_req_ready,
  output logic [N-1:0] isq_req_data,
  input  logic         isq_rsp_valid,
  input  logic [N-1:0] isq_rsp_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] length,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE, SQ_X, SQ_Y, SQ_Z, ISQ_REQ, ISQ_WAIT, SCALE, DONE
  } state_t;

  state_t         state_q;
  logic [N-1:0]   x_q, y_q, z_q, isq_q, len_q;
  logic [N+1:0]   acc_q;
  logic           in_ready_q, req_valid_q, out_valid_q, busy_q;

  // Squares use magnitudes so a single unsigned multiplier serves every product.
  function automatic logic [N-1:0] mag(input logic [N-1:0] c);
    return c[N-1] ? ((~c) + N'(1)) : c;
  endfunction

  logic [N-1:0]   op_a, op_b, prod_sat;
  logic [2*N-1:0] prod, prod_sh;
  logic [N+1:0]   acc_add, acc_sat;

  always_comb begin
    op_a = isq_q;
    op_b = acc_q[N-1:0];
    case (state_q)
      SQ_X:    begin op_a = mag(x_q); op_b = mag(x_q); end
      SQ_Y:    begin op_a = mag(y_q); op_b = mag(y_q); end
      SQ_Z:    begin op_a = mag(z_q); op_b = mag(z_q); end
      default: ;
    endcase
  end

  assign prod     = {{N{1'b0}}, op_a} * {{N{1'b0}}, op_b};
  assign prod_sh  = prod >> FRAC;
  // Clamping each term keeps three terms inside the N+2 bit accumulator.
  assign prod_sat = (|prod_sh[2*N-1:N]) ? {N{1'b1}} : prod_sh[N-1:0];
  assign acc_add  = acc_q + {2'b00, prod_sat};
  assign acc_sat  = (|acc_add[N+1:N]) ? {2'b00, {N{1'b1}}} : acc_add;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      isq_q       <= '0;
      len_q       <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      req_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          x_q        <= vec_x;
          y_q        <= vec_y;
          z_q        <= vec_z;
          acc_q      <= '0;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
          state_q    <= SQ_X;
        end
        SQ_X: begin acc_q <= acc_add; state_q <= SQ_Y; end
        SQ_Y: begin acc_q <= acc_add; state_q <= SQ_Z; end
        SQ_Z: begin
          acc_q <= acc_sat;
`ifdef VEC3_LENGTH_ZERO_BYPASS_EN
          if (acc_sat == '0) begin
            len_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            req_valid_q <= 1'b1;
            state_q     <= ISQ_REQ;
          end
`else
          req_valid_q <= 1'b1;
          state_q     <= ISQ_REQ;
`endif
        end
        ISQ_REQ: if (isq_req_ready) begin
          req_valid_q <= 1'b0;
          state_q     <= ISQ_WAIT;
        end
        ISQ_WAIT: if (isq_rsp_valid) begin
          isq_q   <= isq_rsp_data;
          state_q <= SCALE;
        end
        SCALE: begin
          len_q       <= prod_sat;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign isq_req_valid = req_valid_q;
  assign isq_req_data  = acc_q[N-1:0];
  assign out_valid     = out_valid_q;
  assign length        = len_q;
  assign busy          = busy_q;

endmodule
